// File: rtl/msgdma_desc_sequencer.sv
// Splits one (address, length) transfer request into mSGDMA descriptors and writes them to the
// dispatcher over Avalon-MM, honouring the descriptor-buffer-full flag, then waits for idle.
module msgdma_desc_sequencer #(
  parameter logic [31:0] CSR_BASE  = 32'h0000_0000,
  parameter logic [31:0] DESC_BASE = 32'h0000_0020,
  parameter logic [31:0] MAX_CHUNK = 32'h0000_1000
) (
  input  logic        clk_100_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] xfer_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] desc_count,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  typedef enum logic [3:0] {
    IDLE, STAT_RD, STAT_WT, WR_RADDR, WR_WADDR, WR_LEN, WR_CTRL, DRAIN_RD, DRAIN_WT, DONE
  } state_t;

  state_t      state;
  logic [31:0] cur_addr;
  logic [31:0] remaining;
  logic [31:0] chunk;
  logic [31:0] next_chunk;
  logic        last_desc;
  logic        bad_request;
  logic        unused_readdata;

  assign next_chunk  = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
  assign last_desc   = (remaining == chunk);
  assign bad_request = (xfer_len == 32'd0) || (xfer_len[1:0] != 2'b00) || (src_addr[1:0] != 2'b00);
  // Only the full (bit2) and busy (bit0) status flags matter here.
  assign unused_readdata = ^{avm_readdata[31:3], avm_readdata[1]};

  always_ff @(posedge clk_100_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      desc_count    <= 16'd0;
      avm_address   <= 32'd0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'd0;
      avm_read      <= 1'b0;
      cur_addr      <= 32'd0;
      remaining     <= 32'd0;
      chunk         <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_request) begin
              err <= 1'b1;
            end else begin
              cur_addr    <= src_addr;
              remaining   <= xfer_len;
              desc_count  <= 16'd0;
              busy        <= 1'b1;
              avm_read    <= 1'b1;
              avm_address <= CSR_BASE;
              state       <= STAT_RD;
            end
          end
        end
        STAT_RD, DRAIN_RD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= (state == STAT_RD) ? STAT_WT : DRAIN_WT;
          end
        end
        STAT_WT: begin
          if (avm_readdatavalid) begin
            if (avm_readdata[2]) begin
              avm_read <= 1'b1;
              state    <= STAT_RD;
            end else begin
              chunk         <= next_chunk;
              avm_write     <= 1'b1;
              avm_address   <= DESC_BASE;
              avm_writedata <= cur_addr;
              state         <= WR_RADDR;
            end
          end
        end
        WR_RADDR: begin
          if (!avm_waitrequest) begin
            avm_address   <= DESC_BASE + 32'h4;
            avm_writedata <= 32'd0;
            state         <= WR_WADDR;
          end
        end
        WR_WADDR: begin
          if (!avm_waitrequest) begin
            avm_address   <= DESC_BASE + 32'h8;
            avm_writedata <= chunk;
            state         <= WR_LEN;
          end
        end
        WR_LEN: begin
          if (!avm_waitrequest) begin
            avm_address   <= DESC_BASE + 32'hC;
            avm_writedata <= last_desc ? 32'h8000_4000 : 32'h8000_0000;
            state         <= WR_CTRL;
          end
        end
        WR_CTRL: begin
          if (!avm_waitrequest) begin
            avm_write   <= 1'b0;
            cur_addr    <= cur_addr + chunk;
            remaining   <= remaining - chunk;
            desc_count  <= desc_count + 16'd1;
            avm_read    <= 1'b1;
            avm_address <= CSR_BASE;
            state       <= last_desc ? DRAIN_RD : STAT_RD;
          end
        end
        DRAIN_WT: begin
          if (avm_readdatavalid) begin
            if (avm_readdata[0]) begin
              avm_read <= 1'b1;
              state    <= DRAIN_RD;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msgdma_desc_sequencer.sv
// Directed bench for msgdma_desc_sequencer: an Avalon-MM slave model logs descriptor writes and
// serves status reads whose full/busy flags are scripted by read index.
module tb_msgdma_desc_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          reads;
  } wr_t;

  logic        clk_100_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] xfer_len = 32'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] desc_count;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest;

  int read_count = 0;
  int stall_count = 0;
  int strobe_count = 0;
  int overlap_count = 0;
  int done_pulses = 0;
  int err_pulses = 0;
  int full_until = 0;
  int busy_until = 0;
  int stall_until = 0;
  int check_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  wr_t         wq[$];
  logic [63:0] stall_q[$];

  msgdma_desc_sequencer dut (
    .clk_100_clk      (clk_100_clk),
    .reset_reset      (reset_reset),
    .start            (start),
    .src_addr         (src_addr),
    .xfer_len         (xfer_len),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .desc_count       (desc_count),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_read         (avm_read),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest)
  );

  always #5 clk_100_clk = ~clk_100_clk;

  // Stall only the length write, for a scripted number of cycles.
  assign avm_waitrequest = avm_write && (avm_address == 32'h28) && (stall_count < stall_until);

  // Slave model: 1-cycle read latency; status flags depend on the index of the read.
  always @(posedge clk_100_clk) begin
    avm_readdatavalid <= 1'b0;
    if (avm_read && !avm_waitrequest) begin
      avm_readdatavalid <= 1'b1;
      avm_readdata      <= {29'd0, (read_count < full_until), 1'b0, (read_count < busy_until)};
      read_count        <= read_count + 1;
    end
    if (avm_write && !avm_waitrequest) wq.push_back('{avm_address, avm_writedata, read_count});
    if (avm_waitrequest) begin
      stall_q.push_back({avm_address, avm_writedata});
      stall_count <= stall_count + 1;
    end
    if (avm_read || avm_write) strobe_count <= strobe_count + 1;
    if (avm_read && avm_write) overlap_count <= overlap_count + 1;
    if (done === 1'b1) done_pulses <= done_pulses + 1;
    if (err === 1'b1) err_pulses <= err_pulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len);
    @(negedge clk_100_clk);
    start    = 1'b1;
    src_addr = addr;
    xfer_len = len;
    @(negedge clk_100_clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 2000) begin
      @(negedge clk_100_clk);
      cycles++;
    end
  endtask

  task automatic checkDesc(input string tag, input int idx, input logic [31:0] rd,
                           input logic [31:0] len, input logic [31:0] ctrl);
    if (idx + 3 < wq.size()) begin
      checkOutput({tag, "_raddr"}, {wq[idx].addr, wq[idx].data}, {32'h20, rd});
      checkOutput({tag, "_waddr"}, {wq[idx+1].addr, wq[idx+1].data}, {32'h24, 32'h0});
      checkOutput({tag, "_len"}, {wq[idx+2].addr, wq[idx+2].data}, {32'h28, len});
      checkOutput({tag, "_ctrl"}, {wq[idx+3].addr, wq[idx+3].data}, {32'h2C, ctrl});
    end else begin
      checkOutput({tag, "_missing"}, 64'(wq.size()), 64'(idx + 4));
    end
  endtask

  initial begin
    int cyc;
    int w0;
    int r0;
    int s0;
    int st0;
    int e0;
    logic [31:0] bad_addr[3];
    logic [31:0] bad_len[3];

    // Reset state
    repeat (3) @(negedge clk_100_clk);
    checkOutput("reset_outputs", 64'({busy, done, err, avm_write, avm_read, desc_count}), 64'd0);
    checkOutput("reset_addr", 64'(avm_address), 64'd0);
    reset_reset = 1'b0;
    @(negedge clk_100_clk);

    // 0x4000 bytes -> four full descriptors, zero-wait bus
    w0 = wq.size();
    r0 = read_count;
    applyStimulus(32'h1000_0000, 32'h4000);
    checkOutput("t1_first_read", 64'({avm_read, avm_write, busy}), 64'b101);
    checkOutput("t1_first_addr", 64'(avm_address), 64'h0);
    waitDone(cyc);
    checkOutput("t1_latency", 64'(cyc), 64'd26);
    checkOutput("t1_done_busy", 64'({done, busy}), 64'b10);
    checkOutput("t1_count", 64'(desc_count), 64'd4);
    checkOutput("t1_nwrites", 64'(wq.size() - w0), 64'd16);
    for (int i = 0; i < 4; i++)
      checkDesc("t1_desc", w0 + 4 * i, 32'h1000_0000 + 32'(i) * 32'h1000, 32'h1000,
                (i == 3) ? 32'h8000_4000 : 32'h8000_0000);
    @(negedge clk_100_clk);
    checkOutput("t1_done_pulse", 64'(done), 64'd0);
    checkOutput("t1_reads", 64'(read_count - r0), 64'd5);

    // 0x1804 bytes -> 0x1000 + 0x804; dispatcher reports busy for two drain polls
    w0 = wq.size();
    r0 = read_count;
    busy_until = r0 + 4;
    applyStimulus(32'h2000_0000, 32'h1804);
    waitDone(cyc);
    checkOutput("t2_done_seen", 64'(done), 64'd1);
    checkOutput("t2_count", 64'(desc_count), 64'd2);
    checkOutput("t2_reads", 64'(read_count - r0), 64'd5);
    checkOutput("t2_nwrites", 64'(wq.size() - w0), 64'd8);
    checkDesc("t2_desc0", w0, 32'h2000_0000, 32'h1000, 32'h8000_0000);
    checkDesc("t2_desc1", w0 + 4, 32'h2000_1000, 32'h804, 32'h8000_4000);

    // Rejected requests: misaligned length, zero length, misaligned address
    bad_addr = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0002};
    bad_len  = '{32'h1002, 32'h0, 32'h1000};
    st0 = strobe_count;
    e0  = err_pulses;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bad_addr[i], bad_len[i]);
      checkOutput("t3_err_pulse", 64'({err, busy, avm_read, avm_write}), 64'b1000);
      @(negedge clk_100_clk);
      checkOutput("t3_err_clear", 64'({err, busy}), 64'b00);
    end
    checkOutput("t3_no_strobes", 64'(strobe_count - st0), 64'd0);
    checkOutput("t3_err_pulses", 64'(err_pulses - e0), 64'd3);

    // Descriptor buffer full for 10 status polls
    w0 = wq.size();
    r0 = read_count;
    full_until = r0 + 10;
    applyStimulus(32'h3000_0000, 32'h1000);
    waitDone(cyc);
    checkOutput("t4_done_seen", 64'(done), 64'd1);
    if (wq.size() > w0) checkOutput("t4_reads_before_write", 64'(wq[w0].reads - r0), 64'd11);
    else checkOutput("t4_no_write", 64'(wq.size()), 64'(w0 + 4));
    checkDesc("t4_desc", w0, 32'h3000_0000, 32'h1000, 32'h8000_4000);
    checkOutput("t4_reads", 64'(read_count - r0), 64'd12);

    // Length write stalled 5 cycles
    w0 = wq.size();
    s0 = stall_q.size();
    stall_until = stall_count + 5;
    applyStimulus(32'h4000_0000, 32'h1000);
    waitDone(cyc);
    checkOutput("t5_latency", 64'(cyc), 64'd13);
    checkOutput("t5_nstall", 64'(stall_q.size() - s0), 64'd5);
    for (int k = 0; k < 5; k++)
      if (s0 + k < stall_q.size()) checkOutput("t5_stall_hold", stall_q[s0+k], {32'h28, 32'h1000});
    checkOutput("t5_nwrites", 64'(wq.size() - w0), 64'd4);
    checkDesc("t5_desc", w0, 32'h4000_0000, 32'h1000, 32'h8000_4000);

    // Reset during the second descriptor's write-address phase
    w0 = wq.size();
    applyStimulus(32'h5000_0000, 32'h3000);
    cyc = 0;
    while (!(avm_write && avm_address == 32'h24 && (wq.size() - w0) == 5) && cyc < 200) begin
      @(negedge clk_100_clk);
      cyc++;
    end
    checkOutput("t6_reached", 64'({avm_write, desc_count, avm_address}), {15'd0, 1'b1, 16'd1, 32'h24});
    reset_reset = 1'b1;
    @(negedge clk_100_clk);
    checkOutput("t6_after_reset", 64'({busy, avm_write, avm_read, desc_count}), 64'd0);
    reset_reset = 1'b0;
    @(negedge clk_100_clk);
    w0 = wq.size();
    applyStimulus(32'h6000_0000, 32'h1000);
    waitDone(cyc);
    checkOutput("t6_done_seen", 64'(done), 64'd1);
    checkOutput("t6_count", 64'(desc_count), 64'd1);
    checkDesc("t6_desc", w0, 32'h6000_0000, 32'h1000, 32'h8000_4000);
    @(negedge clk_100_clk);

    checkOutput("no_overlap", 64'(overlap_count), 64'd0);
    checkOutput("done_pulses", 64'(done_pulses), 64'd5);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
